// File: rtl/bus_memory_responder_pkg.sv
// Shared types and constants for the bus memory responder: bus FSM states,
// address regions and timer register byte offsets.
package bus_memory_responder_pkg;

    typedef enum logic {
        Idle,
        Access
    } BusState;

    typedef enum logic [1:0] {
        Ram,
        Timer,
        Unmapped
    } Region;

    localparam logic [3:0] OffMtimeLo = 4'h0;
    localparam logic [3:0] OffMtimeHi = 4'h4;
    localparam logic [3:0] OffCmpLo   = 4'h8;
    localparam logic [3:0] OffCmpHi   = 4'hC;

endpackage

// File: rtl/bus_memory_responder_if.sv
// Two-phase select/enable/ready bus between the core's bus access unit
// (master) and a memory-style responder (slave).
interface bus_memory_responder_if;

    logic [31:0] addr;
    logic        select;
    logic        enable;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output addr, select, enable, write, wdata,
        input  rdata, ready
    );

    modport slave (
        input  addr, select, enable, write, wdata,
        output rdata, ready
    );

endinterface

// File: rtl/bus_memory_responder_timer.sv
// Machine timer block: free-running 64-bit mtime, mtimecmp, word read mux
// and the registered compare interrupt.
module bus_timer
    import bus_memory_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  offset,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime    <= '0;
            mtimecmp <= '1;
            irq      <= 1'b0;
        end else begin
            irq <= (mtime >= mtimecmp);
            // A write to either mtime half replaces that cycle's increment.
            if (we && offset == OffMtimeLo) begin
                mtime[31:0] <= wdata;
            end else if (we && offset == OffMtimeHi) begin
                mtime[63:32] <= wdata;
            end else begin
                mtime <= mtime + 64'd1;
            end
            if (we && offset == OffCmpLo) begin
                mtimecmp[31:0] <= wdata;
            end
            if (we && offset == OffCmpHi) begin
                mtimecmp[63:32] <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OffMtimeLo: rdata = mtime[31:0];
            OffMtimeHi: rdata = mtime[63:32];
            OffCmpLo:   rdata = mtimecmp[31:0];
            OffCmpHi:   rdata = mtimecmp[63:32];
            default:    rdata = '0;
        endcase
    end

endmodule

// File: rtl/bus_memory_responder.sv
// Responder end of the select/enable/ready bus: word RAM plus machine timer,
// with a configurable number of wait states before ready.
module bus_memory_responder
    import bus_memory_responder_pkg::*;
#(
    parameter int unsigned MemWords   = 16384,
    parameter logic [31:0] MemBase    = 32'h0000_0000,
    parameter logic [31:0] TimerBase  = 32'h4000_0000,
    parameter int unsigned WaitCycles = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    bus_memory_responder_if.slave  bus,
    output logic                   irqTimer
);

    localparam int unsigned IdxW = $clog2(MemWords);

    BusState         state;
    logic [3:0]      wait_count;
    Region           region_q;
    logic [IdxW-1:0] idx_q;
    logic [3:0]      toff_q;
    logic [31:0]     ram_q;
    logic [31:0]     timer_rdata;
    logic [31:0]     mem [MemWords];

    logic [31:0] mem_off;
    logic [31:0] timer_off;
    Region       setup_region;
    logic        setup_fire;
    logic        ready_int;
    logic        commit;
    logic        unused_addr_bits;

    assign mem_off          = bus.addr - MemBase;
    assign timer_off        = bus.addr - TimerBase;
    assign unused_addr_bits = ^{mem_off[1:0], timer_off[1:0]};

    always_comb begin
        setup_region = Unmapped;
        if (mem_off[31:IdxW+2] == '0) begin
            setup_region = Ram;
        end else if (timer_off[31:4] == '0) begin
            setup_region = Timer;
        end
    end

    assign setup_fire = (state == Idle) && bus.select && !bus.enable;
    assign ready_int  = (state == Access) && bus.select && bus.enable && (wait_count == 4'd0);
    assign commit     = ready_int && bus.write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= Idle;
            wait_count <= '0;
            region_q   <= Unmapped;
            idx_q      <= '0;
            toff_q     <= '0;
        end else begin
            case (state)
                Idle: begin
                    if (setup_fire) begin
                        state      <= Access;
                        wait_count <= 4'(WaitCycles);
                        region_q   <= setup_region;
                        idx_q      <= mem_off[IdxW+1:2];
                        toff_q     <= {timer_off[3:2], 2'b00};
                    end
                end
                Access: begin
                    if (!bus.select || ready_int) begin
                        state <= Idle;
                    end else if (wait_count != 4'd0) begin
                        wait_count <= wait_count - 4'd1;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

    // Read address is presented at setup so the word is ready by the first access cycle.
    always_ff @(posedge clk) begin
        if (setup_fire) begin
            ram_q <= mem[mem_off[IdxW+1:2]];
        end
        if (commit && region_q == Ram) begin
            mem[idx_q] <= bus.wdata;
        end
    end

    bus_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .offset (toff_q),
        .wdata  (bus.wdata),
        .we     (commit && region_q == Timer),
        .rdata  (timer_rdata),
        .irq    (irqTimer)
    );

    assign bus.ready = ready_int;

    always_comb begin
        bus.rdata = '0;
        if (ready_int) begin
            case (region_q)
                Ram:     bus.rdata = ram_q;
                Timer:   bus.rdata = timer_rdata;
                default: bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder: one instance with no wait states and
// one with three, sharing a single stimulus bus steered by dut_sel.
module tb_bus_memory_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        select = 1'b0;
    logic        enable = 1'b0;
    logic        write = 1'b0;
    logic [31:0] wdata = '0;
    logic        dut_sel = 1'b0;
    logic        irq0, irq3;
    logic        ready;
    logic [31:0] rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_memory_responder_if bif0 ();
    bus_memory_responder_if bif3 ();

    assign bif0.addr   = addr;
    assign bif0.select = select & ~dut_sel;
    assign bif0.enable = enable & ~dut_sel;
    assign bif0.write  = write;
    assign bif0.wdata  = wdata;
    assign bif3.addr   = addr;
    assign bif3.select = select & dut_sel;
    assign bif3.enable = enable & dut_sel;
    assign bif3.write  = write;
    assign bif3.wdata  = wdata;

    assign ready = dut_sel ? bif3.ready : bif0.ready;
    assign rdata = dut_sel ? bif3.rdata : bif0.rdata;

    bus_memory_responder #(.WaitCycles(0)) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif0),
        .irqTimer (irq0)
    );

    bus_memory_responder #(.WaitCycles(3)) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif3),
        .irqTimer (irq3)
    );

    // One bus transfer; lat counts access cycles up to and including ready.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input bit hold, output logic [31:0] rd, output int lat,
                        output bit nz, output bit extra);
        bit got;
        got = 0; rd = '0; lat = 0; nz = 0; extra = 0;
        @(posedge clk); #1;
        select = 1'b1; enable = 1'b0; write = wr; addr = a; wdata = d;
        @(posedge clk); #1;
        enable = 1'b1;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ready === 1'b1) begin
                got = 1;
                rd = rdata;
            end else if (rdata !== 32'h0) begin
                nz = 1;
            end
        end
        @(posedge clk); #1;
        if (hold) begin
            @(negedge clk);
            extra = (ready !== 1'b0);
            @(posedge clk); #1;
        end
        select = 1'b0; enable = 1'b0; write = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bif0.ready !== 1'b0 || bif3.ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready got %b/%b want 0/0", bif0.ready, bif3.ready);
        end
        checks++;
        if (bif0.rdata !== 32'h0 || bif3.rdata !== 32'h0) begin
            failures++; $display("FAIL reset_rdata got %h/%h want 0", bif0.rdata, bif3.rdata);
        end
        checks++;
        if (irq0 !== 1'b0 || irq3 !== 1'b0) begin
            failures++; $display("FAIL reset_irq got %b/%b want 0/0", irq0, irq3);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_wait0();
        logic [31:0] rd; int lat; bit nz, ex;
        dut_sel = 1'b0;
        xfer(1'b1, 32'h100, 32'hDEADBEEF, 0, rd, lat, nz, ex);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL w0_write_lat got %0d want 1", lat); end
        xfer(1'b0, 32'h100, 32'h0, 0, rd, lat, nz, ex);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL w0_read_lat got %0d want 1", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL w0_read_data got %h want deadbeef", rd); end
        @(negedge clk);
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL w0_idle_rdata got %h want 0", rdata); end
    endtask

    task automatic test_wait3();
        logic [31:0] rd; int lat; bit nz, ex;
        dut_sel = 1'b1;
        xfer(1'b1, 32'h104, 32'hCAFEF00D, 0, rd, lat, nz, ex);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL w3_write_lat got %0d want 4", lat); end
        xfer(1'b0, 32'h104, 32'h0, 1, rd, lat, nz, ex);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL w3_read_lat got %0d want 4", lat); end
        checks++;
        if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL w3_read_data got %h want cafef00d", rd); end
        checks++;
        if (nz !== 1'b0) begin failures++; $display("FAIL w3_wait_rdata got nonzero=%b want 0", nz); end
        checks++;
        if (ex !== 1'b0) begin failures++; $display("FAIL w3_pulse_width got extra=%b want 0", ex); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat; bit nz, ex;
        logic [31:0] v;
        dut_sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = 32'h5A00_0000 | 32'(i * 17);
            xfer(1'b1, 32'h200 + 32'(4 * i), v, 0, rd, lat, nz, ex);
        end
        for (int i = 0; i < 8; i++) begin
            v = 32'h5A00_0000 | 32'(i * 17);
            xfer(1'b0, 32'h200 + 32'(4 * i), 32'h0, 0, rd, lat, nz, ex);
            checks++;
            if (rd !== v || lat !== 1) begin
                failures++; $display("FAIL burst_word%0d got %h lat %0d want %h lat 1", i, rd, lat, v);
            end
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd; int lat; bit nz, ex;
        dut_sel = 1'b0;
        xfer(1'b1, 32'h0, 32'h0BADF00D, 0, rd, lat, nz, ex);
        xfer(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, rd, lat, nz, ex);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL unm_write_lat got %0d want 1", lat); end
        xfer(1'b0, 32'h8000_0000, 32'h0, 0, rd, lat, nz, ex);
        checks++;
        if (rd !== 32'h0 || lat !== 1) begin
            failures++; $display("FAIL unm_read got %h lat %0d want 0 lat 1", rd, lat);
        end
        xfer(1'b0, 32'h0, 32'h0, 0, rd, lat, nz, ex);
        checks++;
        if (rd !== 32'h0BADF00D) begin failures++; $display("FAIL unm_ram_intact got %h want 0badf00d", rd); end
        xfer(1'b0, 32'h4000_0008, 32'h0, 0, rd, lat, nz, ex);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL unm_timer_intact got %h want ffffffff", rd); end
    endtask

    task automatic test_timer();
        logic [31:0] rd; int lat; bit nz, ex;
        logic exp_irq;
        dut_sel = 1'b0;
        xfer(1'b1, 32'h4000_0000, 32'd100, 0, rd, lat, nz, ex);
        xfer(1'b0, 32'h4000_0000, 32'h0, 0, rd, lat, nz, ex);
        checks++;
        if (rd !== 32'd102) begin failures++; $display("FAIL mtime_lo got %0d want 102", rd); end
        xfer(1'b1, 32'h4000_0004, 32'h0, 0, rd, lat, nz, ex);
        xfer(1'b1, 32'h4000_0000, 32'hFFFF_FFFF, 0, rd, lat, nz, ex);
        xfer(1'b0, 32'h4000_0004, 32'h0, 0, rd, lat, nz, ex);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("FAIL mtime_carry got %0d want 1", rd); end

        pulse_reset();
        xfer(1'b1, 32'h4000_000C, 32'h0, 0, rd, lat, nz, ex);
        xfer(1'b1, 32'h4000_0008, 32'd20, 0, rd, lat, nz, ex);
        xfer(1'b1, 32'h4000_0000, 32'h0, 0, rd, lat, nz, ex);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            exp_irq = (k >= 22);
            checks++;
            if (irq0 !== exp_irq) begin
                failures++; $display("FAIL irq_rise_k%0d got %b want %b", k, irq0, exp_irq);
            end
        end
        xfer(1'b1, 32'h4000_000C, 32'hFFFF_FFFF, 0, rd, lat, nz, ex);
        @(negedge clk);
        checks++;
        if (irq0 !== 1'b1) begin failures++; $display("FAIL irq_lag got %b want 1", irq0); end
        @(negedge clk);
        checks++;
        if (irq0 !== 1'b0) begin failures++; $display("FAIL irq_drop got %b want 0", irq0); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; int lat; bit nz, ex;
        dut_sel = 1'b1;
        xfer(1'b1, 32'h304, 32'h1111_1111, 0, rd, lat, nz, ex);
        @(posedge clk); #1;
        select = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h304; wdata = 32'h2222_2222;
        @(posedge clk); #1 enable = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL abort_wait_ready got %b want 0", ready); end
        @(posedge clk); #1 select = 1'b0; enable = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0) begin failures++; $display("FAIL abort_ready got %b want 0", ready); end
        end
        write = 1'b0;
        xfer(1'b0, 32'h304, 32'h0, 0, rd, lat, nz, ex);
        checks++;
        if (rd !== 32'h1111_1111) begin failures++; $display("FAIL abort_ram got %h want 11111111", rd); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd; int lat; bit nz, ex;
        dut_sel = 1'b1;
        xfer(1'b1, 32'h300, 32'hAAAA_5555, 0, rd, lat, nz, ex);
        @(posedge clk); #1;
        select = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h300; wdata = 32'h5A5A_5A5A;
        @(posedge clk); #1 enable = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready_c%0d got %b want 0", k, ready); end
        end
        checks++;
        if (irq3 !== 1'b0) begin failures++; $display("FAIL rstmid_irq got %b want 0", irq3); end
        @(posedge clk); #1 select = 1'b0; enable = 1'b0; write = 1'b0;
        xfer(1'b0, 32'h4000_0000, 32'h0, 0, rd, lat, nz, ex);
        checks++;
        if (rd !== 32'd9 || lat !== 4) begin
            failures++; $display("FAIL rstmid_mtime got %0d lat %0d want 9 lat 4", rd, lat);
        end
        xfer(1'b0, 32'h300, 32'h0, 0, rd, lat, nz, ex);
        checks++;
        if (rd !== 32'hAAAA_5555) begin failures++; $display("FAIL rstmid_ram got %h want aaaa5555", rd); end
    endtask

    initial begin
        test_reset();
        test_wait0();
        test_wait3();
        test_back_to_back();
        test_unmapped();
        test_timer();
        test_abort();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_memory_responder.md
Name: bus_memory_responder

Overview:
- Responder (slave) end of the core's two-phase select/enable/ready bus.
- Serves word reads and writes from an internal RAM and a small machine-timer register block, and drives irqTimer back to the core.
- Used as the simulation and FPGA memory model behind the core's bus access unit.
- Inserts a parameterized number of wait states so the initiator's stall paths get exercised.

Parameters:
- MemWords, 16384, RAM depth in 32-bit words (power of two).
- MemBase, 32'h0000_0000, byte base address of the RAM window (aligned to MemWords*4).
- TimerBase, 32'h4000_0000, byte base of the 16-byte timer window.
- WaitCycles, 1, extra access-phase cycles before ready (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- addr  in  32  byte address; bits [1:0] ignored.
- select  in  1  high during setup and access phases.
- enable  in  1  high during access phase only.
- write  in  1  write strobe; meaningful only while enable=1.
- wdata  in  32  write data.
- rdata  out  32  read data; valid only when ready=1.
- ready  out  1  access complete this cycle.
- irqTimer  out  1  level interrupt, mtime >= mtimecmp.

Behaviour:
- Bus FSM states: Idle, Access.
  - Idle -> Access when select=1 and enable=0 (setup). On that edge, latch addr (word index and region decode), load waitCount=WaitCycles, and present the RAM read address.
  - In Access, ready = select & enable & (waitCount==0), combinational from registers.
  - While waitCount!=0 it decrements once per cycle.
  - Access -> Idle on the cycle ready=1, or if select drops (abort: no write, no ready).
  - With WaitCycles=0, ready is asserted in the first access cycle. In general, access latency is WaitCycles+1 cycles after setup.
- Address decode uses the address latched at setup.
  - RAM hit: addr in [MemBase, MemBase+MemWords*4).
  - Timer hit: addr in [TimerBase, TimerBase+16).
  - Otherwise unmapped.
- Reads:
  - RAM is synchronous-read, with the address registered at setup.
  - rdata = selected word when ready=1, else 32'h0.
  - Unmapped reads return 32'h0; ready still asserts, since the bus has no error signal.
- Writes: committed on the clock edge where ready=1 and write=1.
  - write sampled in earlier wait cycles is ignored.
  - Unmapped writes are dropped silently.
- Timer registers (word offsets):
  - 0x0 mtime[31:0], 0x4 mtime[63:32], 0x8 mtimecmp[31:0], 0xC mtimecmp[63:32].
  - mtime increments by 1 every cycle, wrapping 2^64-1 -> 0.
  - A bus write to a mtime half wins over the increment that cycle: that half takes wdata, and the other half is held, with no carry that cycle.
  - irqTimer is registered: irqTimer <= (mtime >= mtimecmp), unsigned 64-bit compare, one-cycle lag.
  - Half-written mtimecmp may transiently raise irqTimer; software writes the high half to all-ones first.
- Reset values: state=Idle, ready=0, rdata=0, waitCount=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, irqTimer=0. RAM contents are not reset.
- Reset mid-access: the transaction is abandoned, no write occurs, and ready stays 0.
- enable=1 seen while in Idle (no setup) is ignored; the block stays Idle.
- Back-to-back: the initiator inserts one select-low cycle between words. The block accepts a new setup in the cycle immediately after ready.

Decomposition:
- Shared package: BusState enum (Idle, Access), timer offset constants (0x0/0x4/0x8/0xC), and a region enum (Ram, Timer, Unmapped).
- Sub-module bus_timer: holds mtime/mtimecmp, the write port (offset, wdata, we), the read mux, and the irqTimer register.
- The RAM is an inferred array in the top module.

Test Plan:
- WaitCycles=0: write 0xDEADBEEF to 0x100, then read 0x100 -> ready in first access cycle; rdata=0xDEADBEEF; rdata=0 on all non-ready cycles.
- WaitCycles=3: read 0x104 -> ready low for 3 access cycles, high on the 4th; single-cycle ready pulse.
- Burst of 8 words (line fill pattern 0x200..0x21C, select gap of 1 cycle between words) -> each word returned in order, no lost or duplicated ready.
- Unmapped read and write to 0x8000_0000 -> ready asserted, rdata=0, RAM and timer unchanged.
- Timer: write mtimecmp hi=0 then lo=20, with mtime reset to 0 -> irqTimer rises at cycle 21 (one-cycle lag); write mtimecmp hi=0xFFFFFFFF -> irqTimer drops the next cycle.
- Abort and reset: drop select mid-wait during a write -> no RAM update. Assert rst during access -> ready=0, mtime=0, irqTimer=0, and the next setup is served normally.
